cv32e40p_alu_ft_spare_ctrl: RTL and testbench
=============================================

# cv32e40p_alu_ft_spare_ctrl

Reconfiguration controller for the fault-tolerant ALU (four replicas, three voter input muxes, one standby). It tracks which replicas are permanently faulty, chooses the standby replica, and drives the voter mux selects and per-replica clock enables. It holds issue while swapping and periodically rotates the standby for latent-fault exposure. It sits in EX beside the fault-tolerant ALU and consumes the flags produced by the ALU error counter.

## Interface
- ROTATE_PERIOD, default 1024: accepted ALU ops between standby rotations; 0 disables rotation (max 65535).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- permanent_faulty_i  in  4  per-replica permanent-fault flag from the error counter, bit k = replica k; level or pulse.
- alu_en_i  in  1  ALU op valid in EX.
- ex_ready_i  in  1  EX accepts/retires current op.
- alu_busy_i  in  1  multicycle ALU op (divide) in flight.
- sel_mux_o  out  3  voter slot k takes replica k when 1, replica 3 when 0.
- clock_en_o  out  4  input-pipe clock enable per replica.
- standby_o  out  2  index of current standby replica.
- hold_o  out  1  ID must not issue new ALU ops.
- reconfig_done_o  out  1  one-cycle pulse when a new mapping takes effect.
- spare_faulty_o  out  1  exactly one faulty replica and it is the standby.
- degraded_o  out  1  two or more faulty replicas; sticky until reset.

## Operation
- Registers: standby_q[1:0], faulty_q[3:0] (sticky OR of permanent_faulty_i), state, target_q[1:0], rot_cnt_q[15:0].
- F = faulty_q | permanent_faulty_i (used by next-state logic); nF = popcount(F).
- Mapping from standby s:
  - clock_en_o = ~(1<<s).
  - sel_mux_o bit k = (k != s) for k=0..2.
  - Examples: s=3 gives 111/0111, s=0 gives 110/1110, s=1 gives 101/1101, s=2 gives 011/1011.
- States: NORMAL, DRAIN, WARMUP, COMMIT, DEGRADED.
- NORMAL, first match wins:
  - nF>=2: go to DEGRADED.
  - nF==1 and the faulty replica f != s: target_q=f, go to DRAIN.
  - nF==0, ROTATE_PERIOD!=0, and alu_en_i&ex_ready_i with rot_cnt_q==ROTATE_PERIOD-1: target_q=(s+1) mod 4, rot_cnt_q=0, go to DRAIN.
  - Otherwise rot_cnt_q increments on alu_en_i&ex_ready_i.
- DRAIN: hold_o=1.
  - nF>=2: go to DEGRADED.
  - F[s]=1 (standby now faulty): abort to NORMAL.
  - Single faulty active f != target_q: retarget target_q=f, stay in DRAIN.
  - alu_busy_i=0: go to WARMUP.
- WARMUP: hold_o=1, clock_en_o=1111, mapping unchanged, one cycle. standby_q=target_q on exit. Cannot be aborted.
- COMMIT: hold_o=1, new mapping driven, reconfig_done_o=1, one cycle. Then go to NORMAL; new faults are re-evaluated there.
- DEGRADED: mapping frozen, hold_o=0, degraded_o=1. Exit only via rst.
- Rotation counter is held outside NORMAL and cleared on any transition into DRAIN.

## Timing
- Reset values:
  - standby_o=3, sel_mux_o=111, clock_en_o=0111, hold_o=0.
  - reconfig_done_o=0, spare_faulty_o=0, degraded_o=0.
  - faulty_q=0, rot_cnt_q=0, state NORMAL.
- Fault latency: permanent_faulty_i high in cycle 0 with alu_busy_i=0 gives:
  - Cycle 1: DRAIN, hold_o=1.
  - Cycle 2: WARMUP.
  - Cycle 3: COMMIT, new mapping, done pulse.
  - Cycle 4: NORMAL, hold_o=0.
- DRAIN lasts 1 + (cycles alu_busy_i stays high).
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.
- A simultaneous rotation trigger and fault: the fault wins.
- A pulse on permanent_faulty_i is captured permanently in faulty_q.
- rst asserted mid-swap returns immediately to the reset mapping and clears faulty_q.

## Test plan
- Reset, then no faults, ROTATE_PERIOD=0, 100 ops: required outputs stay sel=111, clock_en=0111, hold=0.
- permanent_faulty_i=0010 for one cycle, alu_busy_i=0: required hold_o high cycles 1-3, clock_en=1111 in cycle 2, and sel=101, clock_en=1101, standby=1 with done pulse in cycle 3.
- Same fault with alu_busy_i high for 5 cycles: required DRAIN lasts 6 cycles, then WARMUP and COMMIT as above.
- ROTATE_PERIOD=4, 4 accepted ops: required standby 3→0 (sel 110, clock_en 1110). After 4 more ops, standby 0→1.
- Rotation in DRAIN with target 0, then a fault on replica 3 (current standby): required abort to NORMAL, standby stays 3, spare_faulty_o=1, rotation suppressed afterwards.
- Faults on 0 and 2 in the same cycle: required degraded_o=1 next cycle, mapping unchanged, hold_o=0. Stays degraded until rst.

Source files
------------

// File: rtl/cv32e40p_alu_ft_spare_ctrl.sv
// Spare/standby reconfiguration controller for the four-replica fault-tolerant ALU.
// Tracks permanently faulty replicas, drains and warms up before swapping the
// standby, rotates the standby periodically, and freezes once degraded.
module cv32e40p_alu_ft_spare_ctrl #(
  parameter int unsigned ROTATE_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] permanent_faulty_i,
  input  logic       alu_en_i,
  input  logic       ex_ready_i,
  input  logic       alu_busy_i,
  output logic [2:0] sel_mux_o,
  output logic [3:0] clock_en_o,
  output logic [1:0] standby_o,
  output logic       hold_o,
  output logic       reconfig_done_o,
  output logic       spare_faulty_o,
  output logic       degraded_o
);

  localparam int unsigned CNT_W = 16;
  localparam bit ROT_EN = (ROTATE_PERIOD != 0);
  localparam logic [CNT_W-1:0] ROT_LAST = ROT_EN ? CNT_W'(ROTATE_PERIOD - 1) : '0;

  typedef enum logic [2:0] {
    NORMAL,
    DRAIN,
    WARMUP,
    COMMIT,
    DEGRADED
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       standby_q, standby_d;
  logic [1:0]       target_q, target_d;
  logic [3:0]       faulty_q, faulty_d;
  logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;

  logic [2:0] nf;
  logic [1:0] f_idx;
  logic       accept;
  logic [2:0] sel_d;
  logic [3:0] clock_en_d;
  logic       hold_d;
  logic       done_d;
  logic       spare_d;
  logic       degraded_d;

  // Replica 's' is the standby: its input pipe is gated and voter slot s (if any) takes replica 3.
  function automatic logic [6:0] map_of(input logic [1:0] s);
    logic [3:0] ce;
    ce = ~(4'b0001 << s);
    return {ce[2:0], ce};
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    faulty_d  = faulty_q | permanent_faulty_i;
    nf        = 3'(faulty_d[0]) + 3'(faulty_d[1]) + 3'(faulty_d[2]) + 3'(faulty_d[3]);
    f_idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (faulty_d[k]) f_idx = 2'(k);
    end
    accept    = alu_en_i & ex_ready_i;
    state_d   = state_q;
    standby_d = standby_q;
    target_d  = target_q;
    rot_cnt_d = rot_cnt_q;

    case (state_q)
      NORMAL: begin
        if (nf >= 3'd2) begin
          state_d = DEGRADED;
        end else if (nf == 3'd1 && f_idx != standby_q) begin
          target_d  = f_idx;
          rot_cnt_d = '0;
          state_d   = DRAIN;
        end else if (nf == 3'd0 && ROT_EN && accept && rot_cnt_q == ROT_LAST) begin
          target_d  = standby_q + 2'd1;
          rot_cnt_d = '0;
          state_d   = DRAIN;
        end else if (accept) begin
          rot_cnt_d = rot_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (nf >= 3'd2) begin
          state_d = DEGRADED;
        end else if (faulty_d[standby_q]) begin
          state_d = NORMAL;
        end else if (nf == 3'd1 && f_idx != target_q) begin
          target_d = f_idx;
        end else if (!alu_busy_i) begin
          state_d = WARMUP;
        end
      end
      WARMUP: begin
        standby_d = target_q;
        state_d   = COMMIT;
      end
      COMMIT:   state_d = NORMAL;
      DEGRADED: state_d = DEGRADED;
      default:  state_d = NORMAL;
    endcase

    {sel_d, clock_en_d} = map_of(standby_d);
    if (state_d == WARMUP) clock_en_d = 4'b1111;
    hold_d     = (state_d == DRAIN) || (state_d == WARMUP) || (state_d == COMMIT);
    done_d     = (state_d == COMMIT);
    spare_d    = (nf == 3'd1) && faulty_d[standby_d];
    degraded_d = (state_d == DEGRADED);
  end

  // State, fault history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= NORMAL;
      standby_q       <= 2'd3;
      target_q        <= 2'd3;
      faulty_q        <= 4'b0000;
      rot_cnt_q       <= '0;
      sel_mux_o       <= 3'b111;
      clock_en_o      <= 4'b0111;
      hold_o          <= 1'b0;
      reconfig_done_o <= 1'b0;
      spare_faulty_o  <= 1'b0;
      degraded_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      standby_q       <= standby_d;
      target_q        <= target_d;
      faulty_q        <= faulty_d;
      rot_cnt_q       <= rot_cnt_d;
      sel_mux_o       <= sel_d;
      clock_en_o      <= clock_en_d;
      hold_o          <= hold_d;
      reconfig_done_o <= done_d;
      spare_faulty_o  <= spare_d;
      degraded_o      <= degraded_d;
    end
  end

  assign standby_o = standby_q;

endmodule

// File: tb/tb_cv32e40p_alu_ft_spare_ctrl.sv
// Scoreboard bench for the ALU spare controller: a driver pushes the expected
// post-edge outputs for every cycle, a monitor pops and compares after each edge.
module tb_cv32e40p_alu_ft_spare_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pf = 4'b0000;
  logic       alu_en = 1'b0;
  logic       ex_ready = 1'b0;
  logic       alu_busy = 1'b0;

  logic [2:0] sel0, sel4;
  logic [3:0] ce0, ce4;
  logic [1:0] sb0, sb4;
  logic       hold0, hold4, done0, done4, spare0, spare4, deg0, deg4;

  cv32e40p_alu_ft_spare_ctrl #(.ROTATE_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst), .permanent_faulty_i(pf), .alu_en_i(alu_en),
    .ex_ready_i(ex_ready), .alu_busy_i(alu_busy), .sel_mux_o(sel0),
    .clock_en_o(ce0), .standby_o(sb0), .hold_o(hold0), .reconfig_done_o(done0),
    .spare_faulty_o(spare0), .degraded_o(deg0)
  );

  cv32e40p_alu_ft_spare_ctrl #(.ROTATE_PERIOD(4)) dut4 (
    .clk(clk), .rst(rst), .permanent_faulty_i(pf), .alu_en_i(alu_en),
    .ex_ready_i(ex_ready), .alu_busy_i(alu_busy), .sel_mux_o(sel4),
    .clock_en_o(ce4), .standby_o(sb4), .hold_o(hold4), .reconfig_done_o(done4),
    .spare_faulty_o(spare4), .degraded_o(deg4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p0;
    logic [2:0] sel;
    logic [3:0] ce;
    logic [1:0] sb;
    logic       hold;
    logic       done;
    logic       spare;
    logic       deg;
    string      nm;
  } exp_t;

  exp_t scb[$];
  int   total = 0;
  int   bad = 0;
  bit   use_p0 = 1'b0;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [3:0] f, input logic en, input logic rdy,
                      input logic busy, input logic [1:0] sb, input logic hold,
                      input logic done, input logic spare, input logic deg,
                      input logic warm, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; pf = f; alu_en = en; ex_ready = rdy; alu_busy = busy;
    e.p0 = use_p0; e.sb = sb; e.hold = hold; e.done = done;
    e.spare = spare; e.deg = deg; e.nm = nm;
    case (sb)
      2'd0:    begin e.sel = 3'b110; e.ce = 4'b1110; end
      2'd1:    begin e.sel = 3'b101; e.ce = 4'b1101; end
      2'd2:    begin e.sel = 3'b011; e.ce = 4'b1011; end
      default: begin e.sel = 3'b111; e.ce = 4'b0111; end
    endcase
    if (warm) e.ce = 4'b1111;
    scb.push_back(e);
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
  endtask

  // Accepted op in NORMAL with standby sb, no fault activity.
  task automatic op(input logic [1:0] sb, input logic spare, input string nm);
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, sb, 1'b0, 1'b0, spare, 1'b0, 1'b0, nm);
  endtask

  // Monitor: compare DUT outputs one time unit after each rising edge.
  initial begin
    exp_t e;
    logic [12:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() != 0) begin
        e = scb.pop_front();
        if (e.p0) got = {sel0, ce0, sb0, hold0, done0, spare0, deg0};
        else      got = {sel4, ce4, sb4, hold4, done4, spare4, deg4};
        want = {e.sel, e.ce, e.sb, e.hold, e.done, e.spare, e.deg};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL %s: got sel/ce/sb/hold/done/spare/deg=%b/%b/%0d/%b/%b/%b/%b want %b/%b/%0d/%b/%b/%b/%b",
                   e.nm, got[12:10], got[9:6], got[5:4], got[3], got[2], got[1], got[0],
                   want[12:10], want[9:6], want[5:4], want[3], want[2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    // No rotation, no faults: mapping must stay put across many ops.
    use_p0 = 1'b1;
    do_reset();
    do_reset();
    for (int i = 0; i < 100; i++) op(2'd3, 1'b0, "norot_op");

    // Single-cycle fault pulse on replica 1, ALU idle.
    use_p0 = 1'b0;
    do_reset();
    step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "f1_drain");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "f1_warmup");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "f1_commit");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "f1_normal");

    // Same fault with a multicycle op in flight for 5 cycles.
    do_reset();
    step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_drain0");
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "busy_drain");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "busy_warmup");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "busy_commit");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "busy_normal");

    // Rotation every 4 accepted ops; an unaccepted op does not count.
    do_reset();
    op(2'd3, 1'b0, "rot_op1");
    op(2'd3, 1'b0, "rot_op2");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rot_stall");
    op(2'd3, 1'b0, "rot_op3");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rot_drain");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rot_warmup");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rot_commit0");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rot_normal0");
    op(2'd0, 1'b0, "rot2_op1");
    op(2'd0, 1'b0, "rot2_op2");
    op(2'd0, 1'b0, "rot2_op3");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rot2_drain");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rot2_warmup");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rot2_commit1");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rot2_normal1");

    // Standby fails while draining for a rotation: abort, then no more rotation.
    do_reset();
    for (int i = 0; i < 3; i++) op(2'd3, 1'b0, "abort_op");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort_drain");
    step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "abort_normal");
    for (int i = 0; i < 8; i++) op(2'd3, 1'b1, "abort_norot");

    // Rotation trigger and a fault on replica 2 in the same cycle: fault wins.
    do_reset();
    for (int i = 0; i < 3; i++) op(2'd3, 1'b0, "race_op");
    step(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "race_drain");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "race_warmup");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "race_commit2");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "race_normal2");

    // Reset mid-swap restores the reset mapping and forgets the fault.
    do_reset();
    step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_drain");
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_reset");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_after");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_after2");

    // Two simultaneous faults: degraded, frozen, sticky until reset.
    do_reset();
    step(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "deg_enter");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "deg_hold1");
    step(1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "deg_hold2");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "deg_hold3");
    do_reset();
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "deg_cleared");

    repeat (3) @(negedge clk);
    if (scb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scb_drain: got %0d pending entries, want 0", scb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
